// File: rtl/fp_row_accumulator.sv
// Row accumulator for FP32 products: iterative align/add/normalise, one term per 4 cycles.
// Truncating arithmetic, denormals flushed; finished row sum leaves on a valid/ready port.
//
// state | meaning
// IDLE  | waiting for a product (in_ready high)
// ALIGN | unpack accumulator and product, shift smaller significand
// ADD   | signed-magnitude add/subtract of aligned significands
// NORM  | normalise, truncate, saturate to Inf/flush to zero, update accumulator
// DONE  | row sum presented on output port until accepted
module fp_row_accumulator #(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [31:0]        in_data,
   input  logic               in_last,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_data,
   output logic [COUNT_W-1:0] out_count
);

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t              r_state;
   logic [31:0]         r_acc;
   logic [31:0]         r_op;
   logic [COUNT_W-1:0]  r_count;
   logic                r_last;
   logic signed [9:0]   r_exp;
   logic [23:0]         r_sig_big;
   logic [23:0]         r_sig_small;
   logic                r_sign_big;
   logic                r_sign_small;
   logic [24:0]         r_sum;
   logic                r_sign;
   logic                r_out_valid;
   logic [31:0]         r_out_data;
   logic [COUNT_W-1:0]  r_out_count;

   logic [7:0]          w_exp_a;
   logic [7:0]          w_exp_b;
   logic [23:0]         w_sig_a;
   logic [23:0]         w_sig_b;
   logic                w_a_big;
   logic [7:0]          w_exp_diff;
   logic [23:0]         w_sig_small_raw;
   logic [23:0]         w_sig_shifted;
   logic [24:0]         w_big25;
   logic [24:0]         w_small25;
   logic [24:0]         w_sum;
   logic                w_sum_sign;
   logic [4:0]          w_lz;
   logic [23:0]         w_norm_sig;
   logic signed [9:0]   w_norm_exp;
   logic [22:0]         w_norm_man;
   logic [31:0]         w_norm_result;

   assign in_ready  = (r_state == IDLE);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_count = r_out_count;

   // A zero exponent means zero: denormal significands are dropped here.
   assign w_exp_a         = r_acc[30:23];
   assign w_exp_b         = r_op[30:23];
   assign w_sig_a         = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, r_acc[22:0]};
   assign w_sig_b         = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, r_op[22:0]};
   assign w_a_big         = (w_exp_a >= w_exp_b);
   assign w_exp_diff      = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);
   assign w_sig_small_raw = w_a_big ? w_sig_b : w_sig_a;
   assign w_sig_shifted   = (w_exp_diff >= 8'd24) ? 24'd0 : (w_sig_small_raw >> w_exp_diff);

   assign w_big25   = {1'b0, r_sig_big};
   assign w_small25 = {1'b0, r_sig_small};

   always_comb begin
      w_sum      = 25'd0;
      w_sum_sign = r_sign_big;
      if (r_sign_big == r_sign_small) begin
         w_sum      = w_big25 + w_small25;
         w_sum_sign = r_sign_big;
      end else if (w_big25 >= w_small25) begin
         w_sum      = w_big25 - w_small25;
         w_sum_sign = r_sign_big;
      end else begin
         w_sum      = w_small25 - w_big25;
         w_sum_sign = r_sign_small;
      end
   end

   // Highest set bit wins, giving the left shift that brings it to bit 23.
   always_comb begin
      w_lz = 5'd0;
      for (int i = 0; i < 24; i++) begin
         if (r_sum[i]) w_lz = 5'(23 - i);
      end
   end

   assign w_norm_sig = r_sum[23:0] << w_lz;
   assign w_norm_exp = r_sum[24] ? (r_exp + 10'sd1) : (r_exp - $signed({5'd0, w_lz}));
   assign w_norm_man = r_sum[24] ? r_sum[23:1] : w_norm_sig[22:0];

   always_comb begin
      w_norm_result = 32'd0;
      if (r_sum == 25'd0)
         w_norm_result = 32'd0;
      else if (w_norm_exp >= 10'sd255)
         w_norm_result = {r_sign, 8'hFF, 23'd0};
      else if (w_norm_exp <= 10'sd0)
         w_norm_result = 32'd0;
      else
         w_norm_result = {r_sign, w_norm_exp[7:0], w_norm_man};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_acc        <= 32'd0;
         r_op         <= 32'd0;
         r_count      <= '0;
         r_last       <= 1'b0;
         r_exp        <= 10'sd0;
         r_sig_big    <= 24'd0;
         r_sig_small  <= 24'd0;
         r_sign_big   <= 1'b0;
         r_sign_small <= 1'b0;
         r_sum        <= 25'd0;
         r_sign       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_data   <= 32'd0;
         r_out_count  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_op   <= in_data;
                  r_last <= in_last;
                  if (r_count != '1) r_count <= r_count + 1'b1;
                  r_state <= ALIGN;
               end
            end
            ALIGN: begin
               r_exp        <= $signed({2'b00, (w_a_big ? w_exp_a : w_exp_b)});
               r_sig_big    <= w_a_big ? w_sig_a : w_sig_b;
               r_sign_big   <= w_a_big ? r_acc[31] : r_op[31];
               r_sig_small  <= w_sig_shifted;
               r_sign_small <= w_a_big ? r_op[31] : r_acc[31];
               r_state      <= ADD;
            end
            ADD: begin
               r_sum   <= w_sum;
               r_sign  <= w_sum_sign;
               r_state <= NORM;
            end
            NORM: begin
               r_acc   <= w_norm_result;
               r_state <= r_last ? DONE : IDLE;
            end
            DONE: begin
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
                  r_out_data  <= r_acc;
                  r_out_count <= r_count;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_acc       <= 32'd0;
                  r_count     <= '0;
                  r_last      <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_row_accumulator.sv
// Bench for fp_row_accumulator: directed rows plus random rows scored against an
// integer-arithmetic model of the truncating align/add/normalise rules.
module tb_fp_row_accumulator;
   localparam int CW   = 3;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_data = 32'd0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [31:0]   out_data;
   logic [CW-1:0] out_count;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t_acc = 0;
   int prev_acc = 0;
   logic [31:0] m_acc = 32'd0;
   int m_cnt = 0;

   fp_row_accumulator #(.COUNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      int ea, eb, e;
      longint ma, mb, s, mag;
      logic sg;
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      ma = (ea == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
      mb = (eb == 0) ? 64'd0 : longint'({1'b1, b[22:0]});
      if (ea >= eb) begin
         e  = ea;
         mb = (ea - eb >= 24) ? 64'd0 : (mb >> (ea - eb));
      end else begin
         e  = eb;
         ma = (eb - ea >= 24) ? 64'd0 : (ma >> (eb - ea));
      end
      s = (a[31] ? -ma : ma) + (b[31] ? -mb : mb);
      if (s == 0) return 32'd0;
      sg  = (s < 0);
      mag = sg ? -s : s;
      while (mag >= 64'd16777216) begin mag = mag / 2; e++; end
      while (mag < 64'd8388608) begin mag = mag * 2; e--; end
      if (e >= 255) return {sg, 8'hFF, 23'd0};
      if (e <= 0) return 32'd0;
      return {sg, 8'(e), mag[22:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] d, input logic l, input int gap, input bit hold);
      int n = 0;
      if (gap > 0) begin
         in_valid = 1'b0;
         repeat (gap) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
      prev_acc = t_acc;
      t_acc    = cyc + 1;
      @(negedge clk);
      if (!hold) begin
         in_valid = 1'b0;
         in_last  = 1'($urandom);
         in_data  = $urandom;
      end
      m_acc = fp_add(m_acc, d);
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
   endtask

   task automatic expect_row(input logic [31:0] exp_d, input int exp_c, input int rdelay, input bit chk_lat);
      int n = 0;
      logic [31:0] held_d;
      logic [CW-1:0] held_c;
      out_ready = 1'b0;
      while (!out_valid && n < 200) begin @(negedge clk); n++; end
      chk("out_valid_wait", {31'd0, out_valid}, 32'd1);
      if (chk_lat) chk("latency", cyc - t_acc, 32'd4);
      chk("out_data", out_data, exp_d);
      chk("out_count", {{(32-CW){1'b0}}, out_count}, exp_c);
      held_d = out_data;
      held_c = out_count;
      repeat (rdelay) begin
         @(negedge clk);
         chk("hold_data", out_data, held_d);
         chk("hold_count", {{(32-CW){1'b0}}, out_count}, {{(32-CW){1'b0}}, held_c});
         chk("hold_valid", {31'd0, out_valid}, 32'd1);
         chk("done_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      out_ready = 1'b0;
      chk("valid_drop", {31'd0, out_valid}, 32'd0);
      chk("ready_back", {31'd0, in_ready}, 32'd1);
      m_acc = 32'd0;
      m_cnt = 0;
   endtask

   function automatic logic [31:0] rnd_fp();
      logic [31:0] r;
      int e;
      r = $urandom;
      e = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(110, 140));
      return {r[31], 8'(e), r[22:0]};
   endfunction

   initial begin
      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_count", {{(32-CW){1'b0}}, out_count}, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // 1.0 + 1.0
      push(32'h3F800000, 1'b0, 0, 1'b0);
      push(32'h3F800000, 1'b1, 1, 1'b0);
      expect_row(32'h40000000, 2, 0, 1'b1);

      // 1 + 2 + 4 with in_valid held high
      push(32'h3F800000, 1'b0, 0, 1'b1);
      push(32'h40000000, 1'b0, 0, 1'b1);
      chk("interval_1", t_acc - prev_acc, 32'd4);
      push(32'h40800000, 1'b1, 0, 1'b0);
      chk("interval_2", t_acc - prev_acc, 32'd4);
      expect_row(32'h40E00000, 3, 0, 1'b1);

      // exact cancellation, then truncation of a tiny term
      push(32'h3FC00000, 1'b0, 0, 1'b0);
      push(32'hBFC00000, 1'b1, 0, 1'b0);
      expect_row(32'h00000000, 2, 0, 1'b0);
      push(32'h3F800000, 1'b0, 2, 1'b0);
      push(32'h30800000, 1'b1, 0, 1'b0);
      expect_row(32'h3F800000, 2, 0, 1'b0);

      // overflow to Inf, denormal single term
      push(32'h7F7FFFFF, 1'b0, 0, 1'b0);
      push(32'h7F7FFFFF, 1'b1, 0, 1'b0);
      expect_row(32'h7F800000, 2, 0, 1'b0);
      push(32'h00000001, 1'b1, 0, 1'b0);
      expect_row(32'h00000000, 1, 0, 1'b0);

      // backpressure in DONE with a pending input that must not be taken
      push(32'h40400000, 1'b1, 0, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h40A00000;
      in_last  = 1'b1;
      expect_row(32'h40400000, 1, 5, 1'b0);
      push(32'h3F800000, 1'b1, 1, 1'b0);
      expect_row(32'h3F800000, 1, 0, 1'b0);

      // count saturation: nine terms of 1.0
      for (int i = 0; i < 9; i++) push(32'h3F800000, (i == 8), 0, 1'b0);
      expect_row(32'h41100000, CMAX, 0, 1'b0);

      // asynchronous reset while in ALIGN mid-row
      push(32'h3F800000, 1'b0, 0, 1'b0);
      push(32'h3F800000, 1'b0, 0, 1'b0);
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst_out_data", out_data, 32'd0);
      chk("midrst_out_count", {{(32-CW){1'b0}}, out_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_acc = 32'd0;
      m_cnt = 0;
      @(negedge clk);
      chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      push(32'h40000000, 1'b0, 0, 1'b0);
      push(32'h3F000000, 1'b1, 0, 1'b0);
      expect_row(32'h40200000, 2, 0, 1'b0);

      // random rows against the model
      for (int r = 0; r < 14; r++) begin
         int len;
         len = int'($urandom_range(1, 10));
         for (int k = 0; k < len; k++) begin
            logic [31:0] d;
            case ($urandom_range(0, 5))
               0: d = (m_acc != 32'd0) ? {~m_acc[31], m_acc[30:0]} : rnd_fp();
               1: d = (m_acc[30:23] != 8'd0) ? {~m_acc[31], m_acc[30:23], 23'($urandom)} : rnd_fp();
               default: d = rnd_fp();
            endcase
            push(d, (k == len - 1), int'($urandom_range(0, 3)), 1'b0);
         end
         expect_row(m_acc, m_cnt, int'($urandom_range(0, 3)), 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fp_row_accumulator.md
Name: fp_row_accumulator

Overview:
- Sits directly downstream of the combinational FP32 multiplier (IMU_fp). Accumulates the stream of FP32 products belonging to one output row into a single FP32 sum.
- Iterative align/add/normalise FSM; one product accepted every 4 cycles.
- Row boundary marked by in_last. The finished sum is presented on a valid/ready output port for the writeback stage.

Parameters:
- COUNT_W, 16, width of the per-row term counter (saturating).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  product on in_data is valid
- in_ready  output  1  block can accept a product this cycle
- in_data  input  32  FP32 product {sign, exp[7:0], man[22:0]}
- in_last  input  1  qualified by in_valid; marks the final product of the row
- out_valid  output  1  row sum available
- out_ready  input  1  downstream accepts the sum
- out_data  output  32  FP32 row sum
- out_count  output  COUNT_W  number of products summed into out_data

Behaviour:
- Reset values (asynchronous; rst asserted at any time, including mid-row or mid-FSM, returns everything immediately):
  - state=IDLE, accumulator=+0.0, count=0, last flag=0
  - out_valid=0, out_data=0, out_count=0
  - in_ready=1 after rst deasserts.
- Transfer rules:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- FSM states: IDLE, ALIGN, ADD, NORM, DONE.
  - in_ready = (state==IDLE). No other state accepts input.
- IDLE:
  - On input transfer: latch in_data and in_last; count increments and saturates at all-ones.
  - Next state ALIGN.
- ALIGN:
  - Unpack both operands to 24-bit significands (hidden 1). Any operand with exp==0 is treated as zero; denormals are flushed.
  - Right-shift the smaller-exponent significand by the exponent difference. A difference of 24 or more gives zero. Shifted-out bits are discarded (no guard/sticky bits).
  - Result exponent = larger exponent. Next state ADD.
- ADD:
  - 25-bit signed-magnitude add/subtract. Equal signs: add magnitudes. Otherwise: subtract smaller from larger, and the sign of the larger wins. Next state NORM.
- NORM:
  - Carry out: shift right 1, exponent +1.
  - Otherwise: shift left until bit 23 is set, decrementing the exponent per position.
  - Truncation only (round toward zero).
  - Exact zero result (including x + (-x)) gives +0.0.
  - Exponent ≥255 gives signed Inf (exp=255, man=0). Exponent ≤0 gives +0.0.
  - Write the result to the accumulator. Next state DONE if the last flag is set, else IDLE.
- DONE:
  - out_valid=1; out_data=accumulator; out_count=count. All three are held stable until out_ready.
  - On output transfer: accumulator=+0.0, count=0, out_valid=0 next cycle, state=IDLE.
- Latency and throughput:
  - Product accepted at edge t: in_ready high again at edge t+4.
  - A last product accepted at t: out_valid=1 during the cycle after edge t+4. Earliest next input accept is the cycle after the output transfer.
- Inputs are not required to be NaN/Inf. Inf operands follow the exponent path and saturate to Inf; NaN results are undefined.
- in_last is ignored when in_valid is low.
- A row of a single product outputs that product; a denormal input gives +0.0, count=1.

Test Plan:
- 0x3F800000 then 0x3F800000 with in_last: out_data=0x40000000 (2.0), out_count=2, out_valid asserted 4 cycles after the last accept.
- 1.0, 2.0, 4.0 (0x3F800000, 0x40000000, 0x40800000 last): out_data=0x40E00000 (7.0), count=3. in_valid held high throughout, so in_ready pulses once every 4 cycles.
- 0x3FC00000 + 0xBFC00000 last: out_data=0x00000000, count=2. Then 0x3F800000 + 0x30800000 (2^-30) last: out_data=0x3F800000 (truncation).
- 0x7F7FFFFF + 0x7F7FFFFF last: out_data=0x7F800000. Single row 0x00000001 last: out_data=0x00000000, count=1.
- out_ready low for 5 cycles in DONE: out_data and out_count stable, in_ready=0. Raise out_ready: one transfer, then the next row starts from +0.0.
- Assert rst in ALIGN mid-row after 2 accepted terms: outputs zero immediately. Following row 2.0+0.5 gives 0x40200000, count=2.
